control_unit: RTL and testbench

Hard-wired sequencer that drives every control input of the datapath: the register file, bus multiplexer, ALU/Z, PC, IR, MAR/MDR, RAM, HI/LO and I/O ports. Runs a fixed fetch (T0–T2) followed by a per-opcode execute sequence. Decodes `IR[31:27]` and samples the CON FF for conditional branches. Sits beside the datapath at the top level and consumes the datapath's `IR_out` and `branch_flag`.

---
 rtl/control_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: hard-wired sequencer for the datapath.
// It runs a fixed fetch (T0, optional T1W wait cycles, T1, T2) and then an execute
// sequence chosen by IR[31:27]. All outputs are Moore-decoded from the state
// register and the opcode. The one exception is the br PC load in T6, which also
// uses CON_FF.
// Ports:
//   clk, clr     : clock; asynchronous active-low reset
//   IR           : instruction register contents (opcode in [31:27])
//   CON_FF       : branch condition, used combinationally in br T6
//   Stop         : level request to pause at the next instruction boundary
//   Read..Rout   : active-high datapath strobes
//   Run          : high while fetching or executing
//   illegal_op   : single-cycle pulse in T3 for an undefined opcode
module control_unit #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic        PC_enable,
  output logic        Z_enable,
  output logic        MDR_enable,
  output logic        MAR_enable,
  output logic        Y_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        IR_enable,
  output logic        OutPort_enable,
  output logic        PCout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        HIout,
  output logic        LOout,
  output logic        MDRout,
  output logic        InPortout,
  output logic        Cout,
  output logic        BAout,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Run,
  output logic        illegal_op
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] WAIT_N    = CNT_W'(MEM_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT - 1);

  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1W, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
    ST_STOPPED, ST_HALTED
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MD, C_BR, C_JR, C_IN, C_OUT,
    C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
  } op_class_t;

  state_t           state;
  state_t           last_step;
  state_t           end_state;
  op_class_t        op_class;
  logic [CNT_W-1:0] wait_cnt;
  logic [OP_W-1:0]  opcode;
  logic             ld_wait;
  logic             seq_done;
  logic             unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  // Opcode to instruction class
  always_comb begin
    op_class = C_ILL;
    case (opcode)
      5'd0:                                     op_class = C_LD;
      5'd1:                                     op_class = C_LDI;
      5'd2:                                     op_class = C_ST;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: op_class = C_ALU;
      5'd11, 5'd12, 5'd13:                      op_class = C_IMM;
      5'd14, 5'd15:                             op_class = C_MD;
      5'd18:                                    op_class = C_BR;
      5'd19:                                    op_class = C_JR;
      5'd21:                                    op_class = C_IN;
      5'd22:                                    op_class = C_OUT;
      5'd23:                                    op_class = C_MFHI;
      5'd24:                                    op_class = C_MFLO;
      5'd25:                                    op_class = C_NOP;
      5'd26:                                    op_class = C_HALT;
      default:                                  op_class = C_ILL;
    endcase
  end

  // Final step of each class; nop and halt finish with the fetch
  always_comb begin
    last_step = ST_T3;
    case (op_class)
      C_LD, C_ST:          last_step = ST_T7;
      C_LDI, C_ALU, C_IMM: last_step = ST_T5;
      C_MD, C_BR:          last_step = ST_T6;
      C_NOP, C_HALT:       last_step = ST_T2;
      default:             last_step = ST_T3;
    endcase
  end

  // ld holds T6 with Read only until the memory wait count is reached
  assign ld_wait   = (state == ST_T6) && (op_class == C_LD) && (wait_cnt != WAIT_N);
  assign seq_done  = (state == last_step) && !ld_wait;
  assign end_state = Stop ? ST_STOPPED : ST_T0;

  // Sequencer state and wait counter
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= ST_RESET;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        ST_RESET: state <= ST_T0;
        ST_T0:    state <= (MEM_WAIT != 0) ? ST_T1W : ST_T1;
        ST_T1W: begin
          if (wait_cnt == WAIT_LAST) state <= ST_T1;
          else                       wait_cnt <= wait_cnt + CNT_W'(1);
        end
        ST_T1: state <= ST_T2;
        ST_T2: begin
          if (op_class == C_HALT) state <= ST_HALTED;
          else if (seq_done)      state <= end_state;
          else                    state <= ST_T3;
        end
        ST_T3: state <= seq_done ? end_state : ST_T4;
        ST_T4: state <= seq_done ? end_state : ST_T5;
        ST_T5: state <= seq_done ? end_state : ST_T6;
        ST_T6: begin
          if (ld_wait)       wait_cnt <= wait_cnt + CNT_W'(1);
          else if (seq_done) state <= end_state;
          else               state <= ST_T7;
        end
        ST_T7:      state <= end_state;
        ST_STOPPED: if (!Stop) state <= ST_T0;
        ST_HALTED:  state <= ST_HALTED;
        default:    state <= ST_RESET;
      endcase
    end
  end

  // Strobe decode from state and opcode class
  always_comb begin
    Read = 1'b0; Write = 1'b0; IncPC = 1'b0; PC_enable = 1'b0; Z_enable = 1'b0;
    MDR_enable = 1'b0; MAR_enable = 1'b0; Y_enable = 1'b0; HI_enable = 1'b0;
    LO_enable = 1'b0; IR_enable = 1'b0; OutPort_enable = 1'b0; PCout = 1'b0;
    ZHighout = 1'b0; ZLowout = 1'b0; HIout = 1'b0; LOout = 1'b0; MDRout = 1'b0;
    InPortout = 1'b0; Cout = 1'b0; BAout = 1'b0; CONin = 1'b0; Gra = 1'b0;
    Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; illegal_op = 1'b0;
    Run = !((state == ST_RESET) || (state == ST_STOPPED) || (state == ST_HALTED));
    case (state)
      ST_T0:  begin PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; PC_enable = 1'b1; end
      ST_T1W: Read = 1'b1;
      ST_T1:  begin Read = 1'b1; MDR_enable = 1'b1; end
      ST_T2:  begin MDRout = 1'b1; IR_enable = 1'b1; end
      ST_T3: begin
        case (op_class)
          C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
          C_ALU, C_IMM:      begin Grb = 1'b1; Rout = 1'b1; Y_enable = 1'b1; end
          C_MD:              begin Gra = 1'b1; Rout = 1'b1; Y_enable = 1'b1; end
          C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          C_JR:              begin Gra = 1'b1; Rout = 1'b1; PC_enable = 1'b1; end
          C_IN:              begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_OUT:             begin Gra = 1'b1; Rout = 1'b1; OutPort_enable = 1'b1; end
          C_MFHI:            begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MFLO:            begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ILL:             illegal_op = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        case (op_class)
          C_LD, C_LDI, C_ST, C_IMM: begin Cout = 1'b1; Z_enable = 1'b1; end
          C_ALU: begin Grc = 1'b1; Rout = 1'b1; Z_enable = 1'b1; end
          C_MD:  begin Grb = 1'b1; Rout = 1'b1; Z_enable = 1'b1; end
          C_BR:  begin PCout = 1'b1; Y_enable = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (op_class)
          C_LD, C_ST:          begin ZLowout = 1'b1; MAR_enable = 1'b1; end
          C_LDI, C_ALU, C_IMM: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MD:                begin ZLowout = 1'b1; LO_enable = 1'b1; end
          C_BR:                begin Cout = 1'b1; Z_enable = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (op_class)
          C_LD: begin Read = 1'b1; MDR_enable = !ld_wait; end
          C_ST: begin Gra = 1'b1; Rout = 1'b1; MDR_enable = 1'b1; end
          C_MD: begin ZHighout = 1'b1; HI_enable = 1'b1; end
          C_BR: begin ZLowout = 1'b1; PC_enable = CON_FF; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (op_class)
          C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: instance 0 with MEM_WAIT=0, instance 1 with MEM_WAIT=2.
// An instruction-level model expands each instruction into its expected per-cycle
// strobe vectors. The bench compares those vectors with the DUT cycle by cycle.
module tb_control_unit;

  localparam int I_READ = 28, I_WRITE = 27, I_INCPC = 26, I_PCEN = 25, I_ZEN = 24;
  localparam int I_MDREN = 23, I_MAREN = 22, I_YEN = 21, I_HIEN = 20, I_LOEN = 19;
  localparam int I_IREN = 18, I_OUTEN = 17, I_PCOUT = 16, I_ZHI = 15, I_ZLO = 14;
  localparam int I_HIOUT = 13, I_LOOUT = 12, I_MDROUT = 11, I_INOUT = 10, I_COUT = 9;
  localparam int I_BAOUT = 8, I_CONIN = 7, I_GRA = 6, I_GRB = 5, I_GRC = 4;
  localparam int I_RIN = 3, I_ROUT = 2, I_RUN = 1, I_ILL = 0;
  localparam logic [31:0] NOP = 32'hC800_0000;

  logic        clk;
  logic        clr;
  logic [31:0] ir   [2];
  logic        con  [2];
  logic        stop [2];
  wire  [28:0] outs [2];

  int total = 0;
  int bad   = 0;
  logic [28:0] exp_q [$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    control_unit #(.MEM_WAIT((g == 0) ? 0 : 2)) dut (
      .clk(clk), .clr(clr), .IR(ir[g]), .CON_FF(con[g]), .Stop(stop[g]),
      .Read(outs[g][I_READ]), .Write(outs[g][I_WRITE]), .IncPC(outs[g][I_INCPC]),
      .PC_enable(outs[g][I_PCEN]), .Z_enable(outs[g][I_ZEN]),
      .MDR_enable(outs[g][I_MDREN]), .MAR_enable(outs[g][I_MAREN]),
      .Y_enable(outs[g][I_YEN]), .HI_enable(outs[g][I_HIEN]),
      .LO_enable(outs[g][I_LOEN]), .IR_enable(outs[g][I_IREN]),
      .OutPort_enable(outs[g][I_OUTEN]), .PCout(outs[g][I_PCOUT]),
      .ZHighout(outs[g][I_ZHI]), .ZLowout(outs[g][I_ZLO]), .HIout(outs[g][I_HIOUT]),
      .LOout(outs[g][I_LOOUT]), .MDRout(outs[g][I_MDROUT]),
      .InPortout(outs[g][I_INOUT]), .Cout(outs[g][I_COUT]), .BAout(outs[g][I_BAOUT]),
      .CONin(outs[g][I_CONIN]), .Gra(outs[g][I_GRA]), .Grb(outs[g][I_GRB]),
      .Grc(outs[g][I_GRC]), .Rin(outs[g][I_RIN]), .Rout(outs[g][I_ROUT]),
      .Run(outs[g][I_RUN]), .illegal_op(outs[g][I_ILL])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [28:0] b(input int i);
    return 29'(1) << i;
  endfunction

  function automatic void push(input logic [28:0] v);
    exp_q.push_back(v | b(I_RUN));
  endfunction

  // Expected strobe vector for every cycle of one instruction, starting at T0
  function automatic void build_seq(input logic [31:0] instr, input int mw, input logic cf);
    int op;
    op = int'(instr[31:27]);
    exp_q.delete();
    push(b(I_PCOUT) | b(I_MAREN) | b(I_INCPC) | b(I_PCEN));
    for (int i = 0; i < mw; i++) push(b(I_READ));
    push(b(I_READ) | b(I_MDREN));
    push(b(I_MDROUT) | b(I_IREN));
    if (op <= 2) begin
      push(b(I_GRB) | b(I_BAOUT) | b(I_YEN));
      push(b(I_COUT) | b(I_ZEN));
      if (op == 1) push(b(I_ZLO) | b(I_GRA) | b(I_RIN));
      else begin
        push(b(I_ZLO) | b(I_MAREN));
        if (op == 0) begin
          for (int i = 0; i < mw; i++) push(b(I_READ));
          push(b(I_READ) | b(I_MDREN));
          push(b(I_MDROUT) | b(I_GRA) | b(I_RIN));
        end else begin
          push(b(I_GRA) | b(I_ROUT) | b(I_MDREN));
          push(b(I_WRITE));
        end
      end
    end else if (op <= 13) begin
      push(b(I_GRB) | b(I_ROUT) | b(I_YEN));
      if (op <= 10) push(b(I_GRC) | b(I_ROUT) | b(I_ZEN));
      else          push(b(I_COUT) | b(I_ZEN));
      push(b(I_ZLO) | b(I_GRA) | b(I_RIN));
    end else if (op <= 15) begin
      push(b(I_GRA) | b(I_ROUT) | b(I_YEN));
      push(b(I_GRB) | b(I_ROUT) | b(I_ZEN));
      push(b(I_ZLO) | b(I_LOEN));
      push(b(I_ZHI) | b(I_HIEN));
    end else begin
      case (op)
        18: begin
          push(b(I_GRA) | b(I_ROUT) | b(I_CONIN));
          push(b(I_PCOUT) | b(I_YEN));
          push(b(I_COUT) | b(I_ZEN));
          push(b(I_ZLO) | (cf ? b(I_PCEN) : 29'd0));
        end
        19: push(b(I_GRA) | b(I_ROUT) | b(I_PCEN));
        21: push(b(I_INOUT) | b(I_GRA) | b(I_RIN));
        22: push(b(I_GRA) | b(I_ROUT) | b(I_OUTEN));
        23: push(b(I_HIOUT) | b(I_GRA) | b(I_RIN));
        24: push(b(I_LOOUT) | b(I_GRA) | b(I_RIN));
        25, 26: ;
        default: push(b(I_ILL));
      endcase
    end
  endfunction

  // Pull clr low for three cycles, release, and check the RESET cycle
  task automatic do_reset(input string name);
    @(negedge clk);
    clr = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < 2; s++) begin
        total++;
        if (outs[s] !== 29'd0) begin
          bad++;
          $display("FAIL %s held dut%0d cyc%0d: got=%h exp=0", name, s, c, outs[s]);
        end
      end
      @(negedge clk);
      #1;
    end
    clr = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      total++;
      if (outs[s] !== 29'd0) begin
        bad++;
        $display("FAIL %s released dut%0d: got=%h exp=0", name, s, outs[s]);
      end
    end
  endtask

  // Run one instruction from T0. This can raise Stop for the boundary or pulse it mid-instruction
  task automatic run_instr(input int sel, input logic [31:0] instr, input logic cf,
                           input bit stop_end, input int pulse_at, input string name);
    int n;
    int hold;
    bit pulse_on;
    pulse_on = 1'b0;
    build_seq(instr, (sel == 0) ? 0 : 2, cf);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        ir[sel]  = instr;
        con[sel] = cf;
      end
      if (pulse_on) begin
        stop[sel] = 1'b0;
        pulse_on  = 1'b0;
      end
      #1;
      total++;
      if (outs[sel] !== exp_q[k]) begin
        bad++;
        $display("FAIL %s dut%0d ir=%h step%0d: got=%h exp=%h",
                 name, sel, instr, k, outs[sel], exp_q[k]);
      end
      if (stop_end && k == n - 2) stop[sel] = 1'b1;
      else if (!stop_end && k == pulse_at && k <= n - 2) begin
        stop[sel] = 1'b1;
        pulse_on  = 1'b1;
      end
    end
    if (stop_end) begin
      hold = $urandom_range(1, 3);
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        #1;
        total++;
        if (outs[sel] !== 29'd0) begin
          bad++;
          $display("FAIL %s stopped dut%0d cyc%0d: got=%h exp=0", name, sel, j, outs[sel]);
        end
      end
      stop[sel] = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_ldi();
    run_instr(0, 32'h0900_0065, 1'b0, 1'b0, -1, "ldi");
  endtask

  task automatic test_br();
    run_instr(0, 32'h9000_0000, 1'b0, 1'b0, -1, "br_con0");
    run_instr(0, 32'h9000_0000, 1'b1, 1'b0, -1, "br_con1");
  endtask

  task automatic test_illegal();
    run_instr(0, 32'hF800_0000, 1'b0, 1'b0, -1, "illegal31");
    run_instr(0, 32'h8000_0000, 1'b0, 1'b0, -1, "illegal16");
  endtask

  task automatic test_random(input int sel, input int count);
    logic [31:0] instr;
    logic [4:0]  op;
    int          pulse;
    bit          stp;
    for (int i = 0; i < count; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd26) op = 5'd25;
      instr = {op, 27'($urandom)};
      stp   = ($urandom_range(0, 4) == 0);
      pulse = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
      run_instr(sel, instr, 1'($urandom_range(0, 1)), stp, pulse, "random");
    end
  endtask

  task automatic test_stop_halt();
    run_instr(0, 32'h1989_0000, 1'b0, 1'b1, -1, "add_stop");
    run_instr(0, 32'hD000_0000, 1'b0, 1'b0, -1, "halt_fetch");
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      stop[0] = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (outs[0] !== 29'd0) begin
        bad++;
        $display("FAIL halted cyc%0d: got=%h exp=0", j, outs[0]);
      end
    end
    stop[0] = 1'b0;
    do_reset("halt_reset");
    ir[0] = NOP;
  endtask

  task automatic test_add_wait();
    run_instr(1, 32'h1989_0000, 1'b0, 1'b0, -1, "add_wait");
  endtask

  // Reset during T6 of st: outputs drop at once and Write never appears
  task automatic test_reset_mid_st();
    logic [31:0] instr;
    int t6;
    instr = {5'd2, 27'($urandom)};
    build_seq(instr, 2, 1'b0);
    t6 = 2 + 3 + 3;
    for (int k = 0; k <= t6; k++) begin
      @(negedge clk);
      if (k == 0) ir[1] = instr;
      #1;
      total++;
      if (outs[1] !== exp_q[k]) begin
        bad++;
        $display("FAIL st_pre step%0d: got=%h exp=%h", k, outs[1], exp_q[k]);
      end
    end
    clr = 1'b0;
    #1;
    total++;
    if (outs[1] !== 29'd0) begin
      bad++;
      $display("FAIL st_async_clear: got=%h exp=0", outs[1]);
    end
    for (int j = 0; j < 2; j++) begin
      @(posedge clk);
      #1;
      total++;
      if (outs[1] !== 29'd0) begin
        bad++;
        $display("FAIL st_in_reset cyc%0d: got=%h exp=0", j, outs[1]);
      end
    end
    @(negedge clk);
    clr = 1'b1;
    #1;
    total++;
    if (outs[1] !== 29'd0) begin
      bad++;
      $display("FAIL st_released: got=%h exp=0", outs[1]);
    end
    run_instr(1, NOP, 1'b0, 1'b0, -1, "after_st_reset");
  endtask

  initial begin
    clr = 1'b1;
    for (int s = 0; s < 2; s++) begin
      ir[s]   = NOP;
      con[s]  = 1'b0;
      stop[s] = 1'b0;
    end
    #1 clr = 1'b0;
    test_reset();
    test_ldi();
    test_br();
    test_illegal();
    test_random(0, 40);
    test_stop_halt();
    test_add_wait();
    test_random(1, 30);
    test_reset_mid_st();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
